// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, press/release/step pulses.
// Optional auto-repeat on btn_step is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_step
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1, REPEAT_DELAY/REPEAT_PERIOD >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    CHK_HIGH,
    HELD,
    CHK_LOW
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int RW   = $clog2(RMAX + 1);
  // Down-counter: reaching zero while still HELD fires a step and reloads the period.
  logic [RW-1:0] rep;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_step    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep         <= '0;
`endif
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_step    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep         <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (s2) begin
            state <= CHK_HIGH;
            cnt   <= '0;
          end
        end
        CHK_HIGH: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
            btn_step  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep       <= RW'(REPEAT_DELAY - 1);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= CHK_LOW;
            cnt   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rep == '0) begin
            btn_step <= 1'b1;
            rep      <= RW'(REPEAT_PERIOD - 1);
          end else begin
            rep <= rep - 1'b1;
          end
`endif
        end
        CHK_LOW: begin
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rep   <= RW'(REPEAT_DELAY - 1);
`endif
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bouncing input.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int EXP_REPEATS = 7;
  localparam int EXP_STEP10  = 1;
`else
  localparam int EXP_REPEATS = 0;
  localparam int EXP_STEP10  = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_step;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the delayed input has disagreed with it
  // for D+1 consecutive edges; "held" means level high with no disagreement.
  bit d1, d2;
  bit m_level, m_press, m_release, m_step;
  int m_run, m_age;

  always @(posedge clk) begin
    int  r;
    int  a;
    bit  lv, p, rl, st, held_before;
    if (rst) begin
      d1 <= 0; d2 <= 0;
      m_run <= 0; m_age <= 0;
      m_level <= 0; m_press <= 0; m_release <= 0; m_step <= 0;
    end else begin
      r = m_run; lv = m_level; a = m_age;
      p = 0; rl = 0; st = 0;
      held_before = lv && (r == 0);
      if (d2 != lv) r = r + 1;
      else r = 0;
      if (r == D + 1) begin
        lv = !lv;
        r  = 0;
        a  = 0;
        if (lv) begin p = 1; st = 1; end
        else rl = 1;
      end else if (lv && r == 0) begin
        if (held_before) begin
          a = a + 1;
`ifdef BTN_AUTOREPEAT_EN
          if (a >= RD && ((a - RD) % RP) == 0) st = 1;
`endif
        end else begin
          a = 0;
        end
      end
      d1 <= btn_in; d2 <= d1;
      m_run <= r; m_age <= a; m_level <= lv;
      m_press <= p; m_release <= rl; m_step <= st;
    end
  end

  always @(negedge clk) begin
    if (armed)
      chk("cycle_outputs", int'({btn_level, btn_press, btn_release, btn_step}),
          int'({m_level, m_press, m_release, m_step}));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int m;
    int left;

    // Reset and idle
    rst = 1; btn_in = 0;
    tick(2);
    armed = 1;
    chk("reset_outputs", int'({btn_level, btn_press, btn_release, btn_step}), 0);
    rst = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n += int'({btn_level, btn_press, btn_release, btn_step});
    end
    chk("idle_quiet", n, 0);

    // Clean press: btn_in sampled high from edge 0
    btn_in = 1;
    tick(6);
    chk("press_not_early", int'(btn_level), 0);
    tick(1);
    chk("press_level", int'(btn_level), 1);
    chk("press_pulse", int'(btn_press), 1);
    chk("press_step", int'(btn_step), 1);
    tick(1);
    chk("press_pulse_one_cycle", int'({btn_press, btn_step}), 0);
    chk("press_level_holds", int'(btn_level), 1);

    // Auto-repeat while held (HELD entered at edge 6 above)
    n = 0; m = 0;
    for (int i = 2; i <= 30; i++) begin
      tick(1);
      n += int'(btn_step);
      m += int'(btn_press);
      if (i == 10) chk("repeat_first_step", int'(btn_step), EXP_STEP10);
    end
    chk("repeat_step_count", n, EXP_REPEATS);
    chk("repeat_no_press", m, 0);

    // Low glitch of 4 cycles while held
    btn_in = 0;
    n = 0; m = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (i == 3) btn_in = 1;
      n += int'(btn_release);
      m += int'(btn_press);
    end
    chk("low_glitch_no_release", n, 0);
    chk("low_glitch_no_press", m, 0);
    chk("low_glitch_level", int'(btn_level), 1);

    // Release
    btn_in = 0;
    tick(6);
    chk("release_not_early", int'({btn_level, btn_release}), 2);
    tick(1);
    chk("release_level", int'(btn_level), 0);
    chk("release_pulse", int'(btn_release), 1);
    tick(1);
    chk("release_pulse_one_cycle", int'(btn_release), 0);
    tick(4);

    // High glitch of 4 cycles
    btn_in = 1;
    tick(4);
    btn_in = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n += int'(btn_press) + int'(btn_level);
    end
    chk("high_glitch_rejected", n, 0);

    // 5-cycle high pulse is accepted
    btn_in = 1;
    tick(5);
    btn_in = 0;
    tick(1);
    chk("pulse5_not_early", int'(btn_press), 0);
    tick(1);
    chk("pulse5_press", int'(btn_press), 1);
    tick(15);
    chk("pulse5_released", int'(btn_level), 0);

    // Reset while in CHK_HIGH
    btn_in = 1;
    tick(4);
    rst = 1;
    tick(1);
    chk("rst_chkhigh_outputs", int'({btn_level, btn_press, btn_release, btn_step}), 0);
    rst = 0; btn_in = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n += int'(btn_press);
    end
    chk("rst_chkhigh_no_press", n, 0);

    // Reset while HELD with button kept pressed
    btn_in = 1;
    tick(8);
    chk("rst_held_pre_level", int'(btn_level), 1);
    rst = 1;
    tick(1);
    chk("rst_held_level_drop", int'(btn_level), 0);
    rst = 0;
    tick(6);
    chk("rst_held_not_early", int'(btn_press), 0);
    tick(1);
    chk("rst_held_repress", int'(btn_press), 1);
    chk("rst_held_relevel", int'(btn_level), 1);

    // Randomized bouncing with occasional reset
    left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        btn_in = ~btn_in;
        left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 7);
      end
      left--;
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage for the clock's user buttons (hour/minute set, mode). It takes a raw, asynchronous, bouncing pushbutton level, synchronizes and debounces it, and produces a clean level plus single-cycle press/release/step pulses. Its outputs drive the `dff`-based edge and toggle registers and the time-set counters downstream. One instance is used per button.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized cycles required to accept a level change; must be ≥1. Production value is 1_000_000 (10 ms at 100 MHz).
- `REPEAT_DELAY`, 10: cycles from press acceptance to the first auto-repeat step; must be ≥2.
- `REPEAT_PERIOD`, 3: cycles between subsequent auto-repeat steps; must be ≥2.
- `clk` input 1: single clock. All state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_in` input 1: raw asynchronous button level, 1 = pressed.
- `btn_level` output 1: debounced level, registered.
- `btn_press` output 1: one-cycle pulse when a press is accepted.
- `btn_release` output 1: one-cycle pulse when a release is accepted.
- `btn_step` output 1: one-cycle pulse on press and on each auto-repeat.

## Operation
- **Synchronizer:** `btn_in` → `s1` → `s2`, two flops. Both reset to 0. Only `s2` is used by the rest of the block.
- **Debounce counter `cnt`:** width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit. It never wraps; it is cleared on every state entry.
- **FSM states:** IDLE, CHK_HIGH, HELD, CHK_LOW. Reset state is IDLE.
- **IDLE:**
  - `s2`=1 → CHK_HIGH, `cnt`=0.
- **CHK_HIGH:**
  - `s2`=0 → IDLE. No output.
  - `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1 → HELD. `btn_level`←1, `btn_press`←1, `btn_step`←1.
  - Otherwise `cnt`++.
- **HELD:**
  - `s2`=0 → CHK_LOW, `cnt`=0.
- **CHK_LOW:**
  - `s2`=1 → HELD. No new press; `btn_level` stays 1. The repeat timer restarts per Configuration.
  - `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE. `btn_level`←0, `btn_release`←1.
  - Otherwise `cnt`++.
- **Pulse width:** `btn_press`, `btn_release` and `btn_step` are high for exactly one cycle. They are never asserted in two consecutive cycles, given the parameter limits.
- **Simultaneous events:** a repeat step is suppressed in the cycle HELD is exited.
- **Reset mid-operation:** reset is honored in any state.
  - Next edge: state IDLE, `s1`/`s2`/`cnt`/repeat timer cleared, all outputs 0.
  - A button held through reset is re-accepted after the full debounce, producing `btn_press`.

## Timing
- **Reset values:** every output is 0 after the first reset edge.
- **Press latency:** `btn_in` sampled 1 at edge 0 and held → `btn_level`=1 and `btn_press`=1 after edge DEBOUNCE_CYCLES+2.
- **Release latency:** symmetric. `btn_level`=0 and `btn_release`=1 after edge DEBOUNCE_CYCLES+2.
- **Glitch rejection:**
  - A high (or low) excursion of ≤DEBOUNCE_CYCLES cycles is rejected.
  - An excursion of ≥DEBOUNCE_CYCLES+1 cycles is accepted.
- **No combinational path** from `btn_in` to any output.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined:** repeat timer active while in HELD.
  - Let HELD be entered at edge E.
  - `btn_step` pulses after edges E+REPEAT_DELAY and E+REPEAT_DELAY+k·REPEAT_PERIOD (k≥1), while the FSM stays in HELD.
  - The timer is cleared whenever the state is not HELD, so a CHK_LOW→HELD return restarts the delay.
- **Not defined:**
  - No repeat timer logic.
  - `btn_step` is identical to `btn_press`.

## Test plan
Default parameters for all scenarios.
- **Reset/idle:** `rst`=1 for 2 edges with `btn_in`=0, then `btn_in`=0 for 20 cycles → all outputs 0 throughout.
- **Clean press:** `btn_in`=1 from edge 0 → `btn_level`=1, `btn_press`=`btn_step`=1 after edge 6; pulses 0 after edge 7; no further `btn_press`.
- **Bounce:**
  - 4-cycle high glitch → no output change.
  - 5-cycle high pulse → `btn_press` after edge 6.
  - Held high with a 4-cycle low glitch → `btn_level` stays 1, no `btn_release`, no second `btn_press`.
- **Release:** from HELD, `btn_in`=0 at edge 0 → `btn_level`=0, `btn_release`=1 after edge 6, for one cycle.
- **Auto-repeat:** hold 30 cycles past HELD entry E.
  - With `BTN_AUTOREPEAT_EN`: `btn_step` after E, E+10, E+13, E+16, E+19, E+22, E+25, E+28.
  - Without it: only after E.
- **Reset mid-operation:**
  - Assert `rst` for 1 edge in CHK_HIGH → no `btn_press`, outputs 0.
  - Assert it in HELD with `btn_in` kept 1 → `btn_level` drops to 0, then `btn_press` again 6 edges after reset deasserts.
